// File: rtl/defines_package.sv
// Shared geometry/colour types used between the geometry front end and the rasterizer.
package defines_package;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D v0;
    Vertex3D v1;
    Vertex3D v2;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

endpackage

// File: rtl/triangle_feeder.sv
// Triangle/colour FIFO feeding the rasterizer one triangle at a time, with
// start/done handshake and end-of-frame tracking.
module triangle_feeder
  import defines_package::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    wr_en,
  input  Triangle3D               wr_triangle,
  input  Color                    wr_color,
  input  logic                    frame_end,
  input  logic                    rast_done,
  output Triangle3D               o_triangle,
  output Color                    o_color,
  output logic                    rast_start,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic                    overflow,
  output logic                    frame_done,
  output logic [CNT_W-1:0]        tri_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  Triangle3D        tri_mem_q [DEPTH];
  Color             col_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  state_t           state_q, state_d;
  Triangle3D        tri_q, tri_d;
  Color             col_q, col_d;
  logic             full_q, empty_q, busy_q, start_q, ovf_q, pend_q, fdone_q;
  logic             pend_d, fdone_d, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_s, pop_s;

  // Handshake FSM: decides when the head entry is popped and presented.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          pop_s   = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rast_done && !empty_q) begin
          pop_s   = 1'b1;
          state_d = ST_START;
        end else if (rast_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping, presented data, frame tracking and counters.
  always_comb begin
    push_s   = wr_en && !full_q;
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
    if (pop_s) begin
      tri_d = tri_mem_q[rd_ptr_q];
      col_d = col_mem_q[rd_ptr_q];
    end else begin
      tri_d = tri_q;
      col_d = col_q;
    end
    ovf_d  = ovf_q || (wr_en && full_q);
    // The pending flag is consumed by the edge that ends the frame_done pulse;
    // frame_done is predicted one edge early so it can be a register.
    pend_d  = fdone_q ? 1'b0 : (pend_q || frame_end);
    fdone_d = pend_d && (state_d == ST_IDLE) && (level_d == '0);
    if (fdone_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_START) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (n_rst && push_s) begin
      tri_mem_q[wr_ptr_q] <= wr_triangle;
      col_mem_q[wr_ptr_q] <= wr_color;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_IDLE;
      tri_q    <= '0;
      col_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      fdone_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      tri_q    <= tri_d;
      col_q    <= col_d;
      full_q   <= (level_d == LVL_FULL);
      empty_q  <= (level_d == '0);
      busy_q   <= (state_d != ST_IDLE);
      start_q  <= (state_d == ST_START);
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      fdone_q  <= fdone_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_triangle = tri_q;
  assign o_color    = col_q;
  assign rast_start = start_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign frame_done = fdone_q;
  assign tri_count  = cnt_q;

endmodule

// File: tb/tb_triangle_feeder.sv
// Directed self-checking bench for triangle_feeder (DEPTH=8, CNT_W=16).
module tb_triangle_feeder;
  import defines_package::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             n_rst, wr_en, frame_end, rast_done;
  Triangle3D        wr_triangle, o_triangle;
  Color             wr_color, o_color;
  logic             rast_start, full, empty, busy, overflow, frame_done;
  logic [3:0]       level;
  logic [CNT_W-1:0] tri_count;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int fd_cnt = 0;

  triangle_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_triangle(wr_triangle),
    .wr_color(wr_color), .frame_end(frame_end), .rast_done(rast_done),
    .o_triangle(o_triangle), .o_color(o_color), .rast_start(rast_start),
    .full(full), .empty(empty), .level(level), .busy(busy),
    .overflow(overflow), .frame_done(frame_done), .tri_count(tri_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rast_start === 1'b1) start_cnt <= start_cnt + 1;
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  function automatic Triangle3D mk_tri(input int n);
    Triangle3D t;
    t.v0.x = 16'(n);       t.v0.y = 16'(n + 100); t.v0.z = 16'(n + 200);
    t.v1.x = 16'(n + 300); t.v1.y = 16'(n + 400); t.v1.z = 16'(n + 500);
    t.v2.x = 16'(n + 600); t.v2.y = 16'(n + 700); t.v2.z = 16'(n + 800);
    return t;
  endfunction

  function automatic Color mk_col(input int n);
    Color c;
    c.r = 8'(n); c.g = 8'(n); c.b = 8'd5;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; wr_en = 1'b0; frame_end = 1'b0; rast_done = 1'b0;
    step(); step();
    n_rst = 1'b1;
  endtask

  task automatic push(input int n);
    wr_en = 1'b1; wr_triangle = mk_tri(n); wr_color = mk_col(n);
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; wr_en = 1'b1; wr_triangle = mk_tri(99); wr_color = mk_col(99);
    frame_end = 1'b0; rast_done = 1'b0;
    step(); step();
    wr_en = 1'b0;
    total++; if ({rast_start, full, empty, busy, overflow, frame_done} !== 6'b001000) begin bad++; $display("FAIL reset_flags: got %b want 001000", {rast_start, full, empty, busy, overflow, frame_done}); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (tri_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", tri_count); end
    total++; if (o_triangle !== Triangle3D'(0) || o_color !== Color'(0)) begin bad++; $display("FAIL reset_data: got %h/%h want 0", o_triangle, o_color); end
    n_rst = 1'b1;
  endtask

  task automatic test_single();
    int s0;
    Color c5;
    c5 = 24'h000005;
    do_reset();
    s0 = start_cnt;
    wr_en = 1'b1; wr_triangle = mk_tri(1); wr_color = c5;
    step();
    wr_en = 1'b0;
    total++; if (rast_start !== 1'b0 || empty !== 1'b0 || level !== 4'd1) begin bad++; $display("FAIL single_c1: start=%b empty=%b level=%0d want 0 0 1", rast_start, empty, level); end
    step();
    total++; if (rast_start !== 1'b1 || busy !== 1'b1 || level !== 4'd0) begin bad++; $display("FAIL single_c2: start=%b busy=%b level=%0d want 1 1 0", rast_start, busy, level); end
    total++; if (o_color !== c5 || o_triangle !== mk_tri(1)) begin bad++; $display("FAIL single_data: got %h/%h want %h/%h", o_triangle, o_color, mk_tri(1), c5); end
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    total++; if (rast_start !== 1'b0 || busy !== 1'b1 || tri_count !== 16'd1) begin bad++; $display("FAIL single_done_in_start: start=%b busy=%b cnt=%0d want 0 1 1", rast_start, busy, tri_count); end
    repeat (3) step();
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    total++; if (busy !== 1'b0 || tri_count !== 16'd1 || o_color !== c5) begin bad++; $display("FAIL single_finish: busy=%b cnt=%0d col=%h want 0 1 5", busy, tri_count, o_color); end
    step();
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    int s0;
    do_reset();
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) push(10 + i);
    total++; if (o_triangle !== mk_tri(10) || level !== 4'd2 || start_cnt - s0 !== 1) begin bad++; $display("FAIL b2b_first: tri=%h level=%0d pulses=%0d want tri10 2 1", o_triangle, level, start_cnt - s0); end
    for (int i = 1; i < 3; i++) begin
      repeat (5) step();
      total++; if (rast_start !== 1'b0) begin bad++; $display("FAIL b2b_quiet%0d: start=%b want 0", i, rast_start); end
      rast_done = 1'b1;
      step();
      rast_done = 1'b0;
      total++; if (rast_start !== 1'b1 || o_triangle !== mk_tri(10 + i) || o_color !== mk_col(10 + i)) begin bad++; $display("FAIL b2b_next%0d: start=%b tri=%h col=%h want 1 %h %h", i, rast_start, o_triangle, o_color, mk_tri(10 + i), mk_col(10 + i)); end
    end
    repeat (5) step();
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    total++; if (busy !== 1'b0 || rast_start !== 1'b0) begin bad++; $display("FAIL b2b_idle: busy=%b start=%b want 0 0", busy, rast_start); end
    repeat (3) step();
    total++; if (start_cnt - s0 !== 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", start_cnt - s0); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) push(20 + i);
    total++; if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || o_triangle !== mk_tri(20)) begin bad++; $display("FAIL ovf_fill: level=%0d full=%b ovf=%b tri=%h want 8 1 0 tri20", level, full, overflow, o_triangle); end
    push(29);
    total++; if (overflow !== 1'b1 || level !== 4'd8) begin bad++; $display("FAIL ovf_drop: ovf=%b level=%0d want 1 8", overflow, level); end
    repeat (3) step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    wr_en = 1'b1; wr_triangle = mk_tri(30); wr_color = mk_col(30); rast_done = 1'b1;
    step();
    wr_en = 1'b0; rast_done = 1'b0;
    total++; if (level !== 4'd7 || full !== 1'b0 || rast_start !== 1'b1 || o_triangle !== mk_tri(21)) begin bad++; $display("FAIL ovf_pop_full: level=%0d full=%b start=%b tri=%h want 7 0 1 tri21", level, full, rast_start, o_triangle); end
    for (int k = 22; k < 29; k++) begin
      step();
      rast_done = 1'b1;
      step();
      rast_done = 1'b0;
      total++; if (o_triangle !== mk_tri(k)) begin bad++; $display("FAIL ovf_order%0d: got %h want %h", k, o_triangle, mk_tri(k)); end
    end
    step();
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    total++; if (busy !== 1'b0 || empty !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_drain: busy=%b empty=%b ovf=%b want 0 1 1", busy, empty, overflow); end
    do_reset();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_reset: got %b want 0", overflow); end
  endtask

  task automatic test_frame();
    int f0;
    do_reset();
    f0 = fd_cnt;
    push(40);
    push(41);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    total++; if (frame_done !== 1'b0 || tri_count !== 16'd1) begin bad++; $display("FAIL frame_early: fd=%b cnt=%0d want 0 1", frame_done, tri_count); end
    rast_done = 1'b1;
    step();
    rast_done = 1'b0; frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    total++; if (tri_count !== 16'd2 || frame_done !== 1'b0) begin bad++; $display("FAIL frame_mid: cnt=%0d fd=%b want 2 0", tri_count, frame_done); end
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    total++; if (frame_done !== 1'b1 || tri_count !== 16'd2 || busy !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL frame_pulse: fd=%b cnt=%0d busy=%b empty=%b want 1 2 0 1", frame_done, tri_count, busy, empty); end
    step();
    total++; if (frame_done !== 1'b0 || tri_count !== 16'd0) begin bad++; $display("FAIL frame_after: fd=%b cnt=%0d want 0 0", frame_done, tri_count); end
    repeat (3) step();
    total++; if (fd_cnt - f0 !== 1) begin bad++; $display("FAIL frame_once: got %0d want 1", fd_cnt - f0); end
  endtask

  task automatic test_frame_idle_level();
    do_reset();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL idle_fd: got %b want 1", frame_done); end
    step();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL idle_fd_end: got %b want 0", frame_done); end
    for (int i = 0; i < 5; i++) push(50 + i);
    total++; if (level !== 4'd4) begin bad++; $display("FAIL lvl_fill: got %0d want 4", level); end
    wr_en = 1'b1; wr_triangle = mk_tri(55); wr_color = mk_col(55); rast_done = 1'b1;
    step();
    wr_en = 1'b0; rast_done = 1'b0;
    total++; if (level !== 4'd4 || rast_start !== 1'b1 || o_triangle !== mk_tri(51)) begin bad++; $display("FAIL lvl_rw: level=%0d start=%b tri=%h want 4 1 tri51", level, rast_start, o_triangle); end
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    for (int i = 0; i < 4; i++) push(60 + i);
    total++; if (level !== 4'd3 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre: level=%0d busy=%b want 3 1", level, busy); end
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    total++; if (level !== 4'd0 || rast_start !== 1'b0 || busy !== 1'b0 || empty !== 1'b1 || o_triangle !== Triangle3D'(0)) begin bad++; $display("FAIL mid_rst: level=%0d start=%b busy=%b empty=%b tri=%h want 0 0 0 1 0", level, rast_start, busy, empty, o_triangle); end
    s0 = start_cnt;
    rast_done = 1'b1;
    step();
    rast_done = 1'b0;
    repeat (3) step();
    total++; if (start_cnt !== s0 || busy !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL mid_stray: pulses=%0d busy=%b level=%0d want 0 0 0", start_cnt - s0, busy, level); end
  endtask

  initial begin
    n_rst = 1'b0; wr_en = 1'b0; frame_end = 1'b0; rast_done = 1'b0;
    wr_triangle = '0; wr_color = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_frame();
    test_frame_idle_level();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
